// File: rtl/pueo_uram_reader.sv
// pueo_uram_reader: streams RDLEN wrapped URAM words per trigger through a credit-limited FIFO to AXI4-Stream.
// PUEO_URAM_RD_HEADER_EN prefixes each readout with a header word {A5, seq, start address}.
module pueo_uram_reader #(
    parameter int DATA_W     = 72,
    parameter int ADDRLEN    = 14,
    parameter int RDLEN      = 1024,
    parameter int RD_LAT     = 3,
    parameter int FIFO_DEPTH = 8
) (
    input  logic               memclk,
    input  logic               memclk_rst_i,
    input  logic               trig_i,
    input  logic [ADDRLEN-1:0] trig_addr_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               trig_lost_o,
    output logic               uram_en_o,
    output logic [ADDRLEN-1:0] uram_addr_o,
    input  logic [DATA_W-1:0]  uram_dat_i,
    output logic [DATA_W-1:0]  m_axis_tdata,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic               m_axis_tlast
);
    localparam int CW = ADDRLEN + 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int UW = PW + 1;
`ifdef PUEO_URAM_RD_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif
    localparam logic [CW-1:0] LEN   = CW'(RDLEN);
    localparam logic [CW-1:0] TOT   = CW'(RDLEN + HDR);
    localparam logic [UW-1:0] DEPTH = UW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t              state;
    logic [ADDRLEN-1:0]  addr;
    logic [CW-1:0]       iss_cnt, acc_cnt;
    logic [UW-1:0]       used, wp, rp;
    logic [RD_LAT-1:0]   vld, lst;
    logic [DATA_W:0]     mem [FIFO_DEPTH];
    logic [DATA_W:0]     din, rd;
    logic [DATA_W-1:0]   hdr;
    logic                hdr_wr, issue, fifo_wr, pop, empty;

`ifdef PUEO_URAM_RD_HEADER_EN
    logic        hdr_pend;
    logic [15:0] seq;
    always_comb begin
        hdr = '0;
        hdr[DATA_W-1 -: 8] = 8'hA5;
        hdr[ADDRLEN +: 16] = seq;
        hdr[ADDRLEN-1:0] = addr;
    end
    assign hdr_wr = state == READ && hdr_pend;
    always_ff @(posedge memclk or posedge memclk_rst_i) begin
        if (memclk_rst_i) begin
            hdr_pend <= 1'b0;
            seq <= '0;
        end else begin
            hdr_pend <= state == IDLE ? trig_i : hdr_pend && !hdr_wr;
            seq <= seq + 16'(done_o);
        end
    end
`else
    assign hdr = '0;
    assign hdr_wr = 1'b0;
`endif

    // used = reads in flight + FIFO occupancy, so every issued read has a slot waiting
    assign issue   = state == READ && used + UW'(hdr_wr) < DEPTH;
    assign fifo_wr = vld[RD_LAT-1] | hdr_wr;
    assign din     = {lst[RD_LAT-1], vld[RD_LAT-1] ? uram_dat_i : hdr};
    assign empty   = wp == rp;
    assign pop     = m_axis_tvalid && m_axis_tready;

    assign busy_o        = state != IDLE;
    assign done_o        = state == DRAIN && acc_cnt == TOT;
    assign uram_en_o     = issue;
    assign uram_addr_o   = addr;
    assign m_axis_tvalid = !empty;

    always_comb begin
        rd = mem[rp[PW-1:0]];
        m_axis_tdata = empty ? '0 : rd[DATA_W-1:0];
        m_axis_tlast = !empty && rd[DATA_W];
    end

    always_ff @(posedge memclk) begin
        if (fifo_wr) mem[wp[PW-1:0]] <= din;
    end

    always_ff @(posedge memclk or posedge memclk_rst_i) begin
        if (memclk_rst_i) begin
            state       <= IDLE;
            addr        <= '0;
            iss_cnt     <= '0;
            acc_cnt     <= '0;
            trig_lost_o <= 1'b0;
            vld         <= '0;
            lst         <= '0;
            wp          <= '0;
            rp          <= '0;
            used        <= '0;
        end else begin
            trig_lost_o <= trig_i && state != IDLE;
            vld         <= (vld << 1) | RD_LAT'(issue);
            lst         <= (lst << 1) | RD_LAT'(issue && iss_cnt == LEN - 1'b1);
            wp          <= wp + UW'(fifo_wr);
            rp          <= rp + UW'(pop);
            used        <= used + UW'(issue) + UW'(hdr_wr) - UW'(pop);
            acc_cnt     <= acc_cnt + CW'(pop);
            if (issue) begin
                addr    <= addr + 1'b1;
                iss_cnt <= iss_cnt + 1'b1;
            end
            case (state)
                IDLE: if (trig_i) begin
                    state   <= READ;
                    addr    <= trig_addr_i;
                    iss_cnt <= '0;
                    acc_cnt <= '0;
                end
                READ:    if (issue && iss_cnt == LEN - 1'b1) state <= DRAIN;
                DRAIN:   if (acc_cnt == TOT) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge memclk) disable iff (memclk_rst_i) UW'(wp - rp) <= DEPTH);
endmodule

// File: doc/pueo_uram_reader.md
Name: pueo_uram_reader

Overview:
- Readout engine for the PUEO URAM sample buffer, in the 500 MHz memory clock domain.
- On a trigger it reads RDLEN consecutive URAM words, starting at a supplied address and wrapping modulo the buffer depth.
- It streams the words out on an AXI4-Stream master with full backpressure.
- URAM read latency is absorbed by a credit-limited output FIFO, so no read is ever issued without guaranteed storage.

Parameters:
- DATA_W, 72, URAM word width (bits).
- ADDRLEN, 14, URAM buffer address width; depth = 2^ADDRLEN (4 cascaded URAMs).
- RDLEN, 1024, words read per trigger; 1 <= RDLEN <= 2^ADDRLEN.
- RD_LAT, 3, URAM read latency in memclk cycles, from uram_en_o to valid uram_dat_i.
- FIFO_DEPTH, 8, output FIFO depth; must be >= RD_LAT+2, power of two.

Ports:
- memclk  input  1  memory clock, 500 MHz; sole clock.
- memclk_rst_i  input  1  reset, asynchronous, active-high.
- trig_i  input  1  single-cycle readout request.
- trig_addr_i  input  ADDRLEN  start address, sampled with trig_i.
- busy_o  output  1  readout in progress.
- done_o  output  1  one-cycle pulse when the last word is accepted downstream.
- trig_lost_o  output  1  one-cycle pulse when trig_i arrives while busy.
- uram_en_o  output  1  URAM read enable.
- uram_addr_o  output  ADDRLEN  URAM read address.
- uram_dat_i  input  DATA_W  URAM read data, valid RD_LAT cycles after uram_en_o.
- m_axis_tdata  output  DATA_W  stream data.
- m_axis_tvalid  output  1  stream valid.
- m_axis_tready  input  1  stream ready.
- m_axis_tlast  output  1  marks the final word of a readout.

Behaviour:
- Reset (async assert, sync release): all outputs 0; FIFO empty; state IDLE; all counters 0.
- Reset mid-readout: abandons the readout immediately. No done_o is issued. In-flight URAM data is discarded via the valid pipeline clear.
- States:
  - IDLE: trig_i=1 latches trig_addr_i into the address register, clears issue/accept counters, goes to READ.
  - READ: issues reads. Goes to DRAIN the cycle after the RDLEN-th read is issued.
  - DRAIN: waits for the accept counter to reach RDLEN, then pulses done_o and returns to IDLE.
- busy_o = 1 in READ and DRAIN.
- Credit rule: uram_en_o=1 in a READ cycle only if (reads in flight + FIFO occupancy) < FIFO_DEPTH.
  - Reads in flight are tracked by an RD_LAT-deep valid shift register.
  - FIFO therefore never overflows; overflow is an assertion failure.
- Address: increments by 1 per issued read, wrapping from 2^ADDRLEN-1 to 0.
- FIFO write: on the valid shift register output, uram_dat_i is written to the FIFO.
- Stream:
  - m_axis_tvalid = FIFO not empty.
  - Transfer when tvalid & tready.
  - tdata/tvalid/tlast stay stable while tvalid=1 and tready=0.
- tlast is asserted on the word whose accept index = RDLEN-1, tracked per word in a FIFO side bit.
- Latency: trig_i at cycle 0 gives uram_en_o at cycle 1 and first m_axis_tvalid at cycle RD_LAT+2 (cycle 5 at defaults).
- Throughput: with tready held high, one word per cycle sustained; reads are back-to-back.
- trig_i while busy_o=1: ignored; trig_lost_o pulses the next cycle.
- trig_i in the same cycle as done_o: ignored and counted lost, because the state is not IDLE.
- Accepted trig_i in IDLE takes effect the following cycle, with busy_o=1 that cycle.
- RDLEN = 2^ADDRLEN: reads the full buffer exactly once, ending at trig_addr_i-1.

Optional Feature:
- Macro: PUEO_URAM_RD_HEADER_EN.
- Defined:
  - Each readout is prefixed by one header word, emitted before the data words.
  - Header word bit layout:
    - [DATA_W-1:DATA_W-8] = 8'hA5.
    - [ADDRLEN-1:0] = start address.
    - [ADDRLEN+15:ADDRLEN] = 16-bit readout sequence number, incremented per completed readout, wrapping, reset 0.
    - All other bits 0.
  - The header occupies one FIFO slot and one credit.
  - The stream carries RDLEN+1 words; tlast is still on the final data word.
  - done_o is still issued after RDLEN+1 accepts.
  - First tvalid at cycle 2.
- Undefined: no header; sequence counter absent.

Test Plan:
- Basic readout: defaults, tready=1, trig_i with trig_addr_i=0x0100, memory model with data=address -> 1024 words 0x0100..0x04FF in order; uram_en_o first at cycle 1; first tvalid at cycle 5; tlast only on word 1023; done_o pulses once; busy_o falls the next cycle.
- Wrap: trig_addr_i=0x3F00, RDLEN=1024 -> data 0x3F00..0x3FFF then 0x0000..0x02FF; no gap at the wrap.
- Backpressure: random tready at 30% duty -> identical sequence; no overflow assertion; uram_en_o gaps observed; tdata stable while stalled.
- Lost trigger: trig_i at cycles 10 and 500 during the readout -> trig_lost_o pulses twice; the readout is unaffected; a trig_i 2 cycles after done_o starts a new readout.
- Reset mid-readout: memclk_rst_i asserted at word 300 -> outputs 0 asynchronously; no done_o; a new trig_i after release yields a clean 1024-word readout from the new address.
- Header (PUEO_URAM_RD_HEADER_EN): two readouts from 0x0010 -> first word 0xA5...0000_0010 with sequence 0, second readout sequence 1; 1025 beats each; tlast on beat 1024.
